// File: rtl/nw_job_ctrl.sv
// ---------------------------------------------------------------------------
// nw_job_ctrl -- job sequencer for a Needleman-Wunsch scoring grid.
//
// Accepts one string pair per job, pulses the grid clear, lets the grid run
// until it reports a score or a cycle limit expires, then presents the
// result on a valid/ready response channel.
//
// Ports
//   clk, reset                    clock (rising edge) and async active-low reset
//   req_valid/req_ready           job request handshake
//   req_s1, req_s2                request strings (LENGTH*CWIDTH bits each)
//   grid_reset                    active-high clear to the grid
//   grid_s1, grid_s2              strings held on the grid for the whole job
//   grid_valid, grid_score        grid completion strobe and signed score
//   rsp_valid/rsp_ready           response handshake
//   rsp_score, rsp_timeout        result score and timeout flag
//   rsp_cycles                    RUN cycles taken (TIMEOUT on abort)
//   busy                          high whenever the FSM is not IDLE
//   stat_jobs, stat_timeouts      saturating job / timeout counters
//
// Configuration
//   NW_JOB_STATS_EN  defined   : statistics counters are built.
//                    undefined : stat_* outputs are tied to zero.
// ---------------------------------------------------------------------------
module nw_job_ctrl #(
  parameter int LENGTH     = 10,
  parameter int CWIDTH     = 2,
  parameter int SWIDTH     = 16,
  parameter int CLR_CYCLES = 2,     // 1..255
  parameter int TIMEOUT    = 1023   // 1..65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LENGTH*CWIDTH-1:0]   req_s1,
  input  logic [LENGTH*CWIDTH-1:0]   req_s2,
  output logic                       grid_reset,
  output logic [LENGTH*CWIDTH-1:0]   grid_s1,
  output logic [LENGTH*CWIDTH-1:0]   grid_s2,
  input  logic                       grid_valid,
  input  logic signed [SWIDTH-1:0]   grid_score,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic signed [SWIDTH-1:0]   rsp_score,
  output logic                       rsp_timeout,
  output logic [15:0]                rsp_cycles,
  output logic                       busy,
  output logic [15:0]                stat_jobs,
  output logic [15:0]                stat_timeouts
);

  localparam int SW = LENGTH * CWIDTH;

  // The clear counter is loaded with CLR_CYCLES-1 and CLEAR exits when it
  // reads zero, giving exactly CLR_CYCLES cycles of grid_reset in CLEAR.
  localparam logic [7:0]  CLR_LOAD = 8'(CLR_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] TMO_VAL  = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [7:0]                clr_q, clr_d;
  logic [15:0]               cyc_q, cyc_d;
  logic [SW-1:0]             s1_q, s1_d;
  logic [SW-1:0]             s2_q, s2_d;
  logic signed [SWIDTH-1:0]  score_q, score_d;
  logic                      tmo_q, tmo_d;
  logic [15:0]               cycles_q, cycles_d;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    cyc_d      = cyc_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    score_d    = score_q;
    tmo_d      = tmo_q;
    cycles_d   = cycles_q;
    req_ready  = 1'b0;
    grid_reset = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready  = 1'b1;
        grid_reset = 1'b1;
        if (req_valid) begin
          s1_d    = req_s1;
          s2_d    = req_s2;
          clr_d   = CLR_LOAD;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        grid_reset = 1'b1;
        if (clr_q == 8'd0) begin
          cyc_d   = 16'd0;
          state_d = S_RUN;
        end else begin
          clr_d = clr_q - 8'd1;
        end
      end

      S_RUN: begin
        cyc_d = cyc_q + 16'd1;
        // Completion is tested first so a score arriving on the last
        // allowed cycle wins over the timeout.
        if (grid_valid) begin
          score_d  = grid_score;
          tmo_d    = 1'b0;
          cycles_d = cyc_q;
          state_d  = S_RESP;
        end else if (cyc_q == TMO_LAST) begin
          score_d  = '0;
          tmo_d    = 1'b1;
          cycles_d = TMO_VAL;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      clr_q    <= '0;
      cyc_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      score_q  <= '0;
      tmo_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      cyc_q    <= cyc_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      score_q  <= score_d;
      tmo_q    <= tmo_d;
      cycles_q <= cycles_d;
    end
  end

  assign grid_s1     = s1_q;
  assign grid_s2     = s2_q;
  assign rsp_score   = score_q;
  assign rsp_timeout = tmo_q;
  assign rsp_cycles  = cycles_q;
  assign busy        = (state_q != S_IDLE);

`ifdef NW_JOB_STATS_EN
  logic        rsp_xfer;
  logic [15:0] jobs_q, tmos_q;

  assign rsp_xfer = (state_q == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jobs_q <= '0;
      tmos_q <= '0;
    end else if (rsp_xfer) begin
      if (jobs_q != 16'hFFFF)          jobs_q <= jobs_q + 16'd1;
      if (tmo_q && tmos_q != 16'hFFFF) tmos_q <= tmos_q + 16'd1;
    end
  end

  assign stat_jobs     = jobs_q;
  assign stat_timeouts = tmos_q;
`else
  assign stat_jobs     = 16'd0;
  assign stat_timeouts = 16'd0;
`endif

endmodule

// File: tb/tb_nw_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nw_job_ctrl -- directed bench for nw_job_ctrl (LENGTH=4, CLR_CYCLES=2,
// TIMEOUT=8). Inputs are driven and outputs sampled on the falling edge.
// A table of jobs gives the grid behaviour and the hand-computed response;
// hand-written sequences cover reset, back-pressure and mid-job reset.
// ---------------------------------------------------------------------------
module tb_nw_job_ctrl;

  localparam int LEN = 4;
  localparam int CW  = 2;
  localparam int SWD = 16;
  localparam int CLR = 2;
  localparam int TMO = 8;
  localparam int NV  = 6;

  logic                  clk;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [LEN*CW-1:0]     req_s1, req_s2;
  logic                  grid_reset;
  logic [LEN*CW-1:0]     grid_s1, grid_s2;
  logic                  grid_valid;
  logic signed [SWD-1:0] grid_score;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic signed [SWD-1:0] rsp_score;
  logic                  rsp_timeout;
  logic [15:0]           rsp_cycles;
  logic                  busy;
  logic [15:0]           stat_jobs, stat_timeouts;

  nw_job_ctrl #(
    .LENGTH(LEN), .CWIDTH(CW), .SWIDTH(SWD), .CLR_CYCLES(CLR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s1(req_s1), .req_s2(req_s2),
    .grid_reset(grid_reset), .grid_s1(grid_s1), .grid_s2(grid_s2),
    .grid_valid(grid_valid), .grid_score(grid_score),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_score(rsp_score), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .busy(busy), .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // delay: RUN cycle index on which the grid model raises grid_valid
  //        (255 = never). noise: grid_valid held high during CLEAR.
  typedef struct {
    logic [7:0]         s1;
    logic [7:0]         s2;
    int                 delay;
    logic signed [15:0] score;
    bit                 noise;
    bit                 exp_tmo;
    logic signed [15:0] exp_score;
    int                 exp_cycles;
  } vec_t;

  vec_t vecs [NV];
  vec_t bp;

  int checks;
  int errors;
  int exp_jobs;
  int exp_tmos;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
`ifdef NW_JOB_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Called on a falling edge with the FSM in IDLE; returns on the falling
  // edge of the first CLEAR cycle.
  task automatic accept(input vec_t v);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_s1    = v.s1;
    req_s2    = v.s2;
    @(negedge clk);
    req_valid = 1'b0;
    req_s1    = ~v.s1;
    req_s2    = ~v.s2;
    check("busy_accepted", busy, 1);
    check("req_ready_clear", req_ready, 0);
    check("grid_s1_latched", grid_s1, v.s1);
    check("grid_s2_latched", grid_s2, v.s2);
  endtask

  // Counts CLEAR cycles, then plays the grid model through RUN until
  // rsp_valid, and checks the captured response.
  task automatic run_grid(input vec_t v);
    int n;
    int k;
    int exp_wait;
    n = 0;
    grid_valid = v.noise;
    grid_score = 16'sd99;
    while (grid_reset === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, CLR);
    check("run_busy", busy, 1);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 100) begin
      grid_valid = (k == v.delay);
      grid_score = v.score;
      @(negedge clk);
      k++;
    end
    grid_valid = 1'b0;
    exp_wait = v.exp_tmo ? v.exp_cycles : v.exp_cycles + 1;
    check("run_length", k, exp_wait);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_score", rsp_score, v.exp_score);
    check("rsp_timeout", rsp_timeout, v.exp_tmo);
    check("rsp_cycles", rsp_cycles, v.exp_cycles);
    check("resp_grid_reset", grid_reset, 0);
    check("resp_grid_s1", grid_s1, v.s1);
    check("resp_req_ready", req_ready, 0);
  endtask

  task automatic handshake(input vec_t v);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_jobs++;
    if (v.exp_tmo) exp_tmos++;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_req_ready", req_ready, 1);
    check("post_grid_reset", grid_reset, 1);
    check("stat_jobs", stat_jobs, stat_exp(exp_jobs));
    check("stat_timeouts", stat_timeouts, stat_exp(exp_tmos));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_jobs   = 0;
    exp_tmos   = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_s1     = '0;
    req_s2     = '0;
    grid_valid = 1'b0;
    grid_score = '0;
    rsp_ready  = 1'b0;

    //            s1            s2            dly  score        nz tmo exp_score    cyc
    vecs[0] = '{8'b00011011, 8'b00011011,   5, 16'sd4,       0, 0, 16'sd4,       5};
    vecs[1] = '{8'hC6,       8'h39,         0, -16'sd3,      0, 0, -16'sd3,      0};
    vecs[2] = '{8'hFF,       8'h00,         7, 16'sd100,     0, 0, 16'sd100,     7};
    vecs[3] = '{8'h0F,       8'hF0,       255, 16'sd55,      0, 1, 16'sd0,       8};
    vecs[4] = '{8'h12,       8'h34,         3, 16'sd32767,   1, 0, 16'sd32767,   3};
    vecs[5] = '{8'hAA,       8'h55,         2, -16'sd32768,  0, 0, -16'sd32768,  2};

    // Reset values, with grid_valid and rsp_ready wiggled to show they are
    // ignored while reset is low.
    repeat (2) @(negedge clk);
    grid_valid = 1'b1;
    rsp_ready  = 1'b1;
    @(negedge clk);
    grid_valid = 1'b0;
    rsp_ready  = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_grid_reset", grid_reset, 1);
    check("rst_grid_s1", grid_s1, 0);
    check("rst_grid_s2", grid_s2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_score", rsp_score, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_cycles", rsp_cycles, 0);
    check("rst_busy", busy, 0);
    check("rst_stat_jobs", stat_jobs, 0);
    check("rst_stat_timeouts", stat_timeouts, 0);

    // Release reset with a request already pending: taken on the first edge.
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      accept(vecs[i]);
      run_grid(vecs[i]);
      handshake(vecs[i]);
    end

    // Back-pressure: response held for 10 cycles while a new request waits.
    accept(vecs[1]);
    run_grid(vecs[1]);
    req_valid  = 1'b1;
    req_s1     = 8'hA5;
    req_s2     = 8'h5A;
    grid_valid = 1'b1;
    grid_score = -16'sd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_score", rsp_score, vecs[1].exp_score);
      check("bp_rsp_cycles", rsp_cycles, vecs[1].exp_cycles);
      check("bp_req_ready", req_ready, 0);
      check("bp_grid_s1", grid_s1, vecs[1].s1);
    end
    grid_valid = 1'b0;
    handshake(vecs[1]);
    // Request still high: accepted on the edge after the handshake.
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_busy", busy, 1);
    check("bp_second_s1", grid_s1, 8'hA5);
    check("bp_second_s2", grid_s2, 8'h5A);
    bp    = vecs[3];
    bp.s1 = 8'hA5;
    bp.s2 = 8'h5A;
    run_grid(bp);
    handshake(bp);

    // Reset in the middle of RUN aborts the job at once.
    accept(vecs[3]);
    repeat (CLR + 1) @(negedge clk);
    check("mid_run_grid_reset", grid_reset, 0);
    #2 reset = 1'b0;
    #1;
    check("abort_grid_reset", grid_reset, 1);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_stat_jobs", stat_jobs, 0);
    exp_jobs = 0;
    exp_tmos = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
    end
    reset = 1'b1;
    accept(vecs[0]);
    run_grid(vecs[0]);
    handshake(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a loop bound is ever bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
